exmem_memwb_fwd_source: RTL and testbench

Back-end pipeline block holding the EX/MEM and MEM/WB registers of the 5-stage 16-bit core. It is the producer end of the operand-forwarding interface. It drives the EXMEM_ALUOUT, EXMEM_RegWriteEN, EXMEM_DstRegNum, WB_DATA, MEMWB_RegWriteEN and MEMWB_DstRegNum signals that the execute stage's forward unit consumes. It also drives the data-memory request and detects the one case forwarding cannot cover: a load followed by a dependent instruction. On that case it raises a stall and inserts a bubble.

---
 rtl/exmem_memwb_fwd_source.sv | 101 ++++++++++
 tb/tb_exmem_memwb_fwd_source.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/exmem_memwb_fwd_source.sv
// exmem_memwb_fwd_source: EX/MEM + MEM/WB stage registers; forwarding sources, data-memory request, load-use bubble, retire counter
module exmem_memwb_fwd_source #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 3,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              ex_valid,
  input  logic              ex_flush,
  input  logic [DATA_W-1:0] ex_alu_out,
  input  logic [DATA_W-1:0] ex_store_data,
  input  logic              ex_reg_write_en,
  input  logic [REG_AW-1:0] ex_dst_reg,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  input  logic [REG_AW-1:0] idex_rs,
  input  logic [REG_AW-1:0] idex_rt,
  input  logic              idex_rt_valid,
  input  logic [DATA_W-1:0] mem_read_data,
  output logic [DATA_W-1:0] EXMEM_ALUOUT,
  output logic              EXMEM_RegWriteEN,
  output logic [REG_AW-1:0] EXMEM_DstRegNum,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_rd_en,
  output logic              mem_wr_en,
  output logic [DATA_W-1:0] WB_DATA,
  output logic              MEMWB_RegWriteEN,
  output logic [REG_AW-1:0] MEMWB_DstRegNum,
  output logic              load_use_stall,
  output logic [CNT_W-1:0]  retire_count
);
  logic              exm_valid_q, exm_valid_d, exm_we_q, exm_we_d;
  logic              exm_rd_q, exm_rd_d, exm_wr_q, exm_wr_d;
  logic [DATA_W-1:0] exm_alu_q, exm_alu_d, exm_sd_q, exm_sd_d;
  logic [REG_AW-1:0] exm_dst_q, exm_dst_d;
  logic              mwb_valid_q, mwb_valid_d, mwb_we_q, mwb_we_d;
  logic [DATA_W-1:0] mwb_data_q, mwb_data_d;
  logic [REG_AW-1:0] mwb_dst_q, mwb_dst_d;
  logic [CNT_W-1:0]  retire_q, retire_d;
  logic              bubble;
  assign load_use_stall = exm_valid_q & exm_rd_q & exm_we_q &
                          ((exm_dst_q == idex_rs) | (idex_rt_valid & (exm_dst_q == idex_rt)));
  assign bubble = ex_flush | load_use_stall | !ex_valid;
  always_comb begin
    exm_valid_d = stall ? exm_valid_q : !bubble;
    exm_we_d    = stall ? exm_we_q    : !bubble & ex_reg_write_en;
    exm_rd_d    = stall ? exm_rd_q    : !bubble & ex_mem_read;
    exm_wr_d    = stall ? exm_wr_q    : !bubble & ex_mem_write;
    exm_alu_d   = stall ? exm_alu_q   : bubble ? '0 : ex_alu_out;
    exm_sd_d    = stall ? exm_sd_q    : bubble ? '0 : ex_store_data;
    exm_dst_d   = stall ? exm_dst_q   : bubble ? '0 : ex_dst_reg;
    mwb_valid_d = stall ? mwb_valid_q : exm_valid_q;
    mwb_we_d    = stall ? mwb_we_q    : exm_valid_q & exm_we_q & !exm_wr_q;
    mwb_data_d  = stall ? mwb_data_q  : exm_rd_q ? mem_read_data : exm_alu_q;
    mwb_dst_d   = stall ? mwb_dst_q   : exm_dst_q;
    retire_d    = retire_q + CNT_W'(mwb_valid_q & !stall);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exm_valid_q <= 1'b0;
      exm_we_q    <= 1'b0;
      exm_rd_q    <= 1'b0;
      exm_wr_q    <= 1'b0;
      exm_alu_q   <= '0;
      exm_sd_q    <= '0;
      exm_dst_q   <= '0;
      mwb_valid_q <= 1'b0;
      mwb_we_q    <= 1'b0;
      mwb_data_q  <= '0;
      mwb_dst_q   <= '0;
      retire_q    <= '0;
    end else begin
      exm_valid_q <= exm_valid_d;
      exm_we_q    <= exm_we_d;
      exm_rd_q    <= exm_rd_d;
      exm_wr_q    <= exm_wr_d;
      exm_alu_q   <= exm_alu_d;
      exm_sd_q    <= exm_sd_d;
      exm_dst_q   <= exm_dst_d;
      mwb_valid_q <= mwb_valid_d;
      mwb_we_q    <= mwb_we_d;
      mwb_data_q  <= mwb_data_d;
      mwb_dst_q   <= mwb_dst_d;
      retire_q    <= retire_d;
    end
  end
  assign EXMEM_ALUOUT     = exm_alu_q;
  assign EXMEM_RegWriteEN = exm_we_q;
  assign EXMEM_DstRegNum  = exm_dst_q;
  assign mem_addr         = exm_alu_q;
  assign mem_wdata        = exm_sd_q;
  assign mem_rd_en        = exm_valid_q & exm_rd_q;
  assign mem_wr_en        = exm_valid_q & exm_wr_q;
  assign WB_DATA          = mwb_data_q;
  assign MEMWB_RegWriteEN = mwb_we_q;
  assign MEMWB_DstRegNum  = mwb_dst_q;
  assign retire_count     = retire_q;
endmodule

// File: tb/tb_exmem_memwb_fwd_source.sv
// tb_exmem_memwb_fwd_source: directed vectors with a queue-based scoreboard for write-backs and memory requests
module tb_exmem_memwb_fwd_source;
  logic        clk, rst, stall, ex_valid, ex_flush, ex_reg_write_en, ex_mem_read, ex_mem_write, idex_rt_valid;
  logic [15:0] ex_alu_out, ex_store_data, mem_read_data;
  logic [2:0]  ex_dst_reg, idex_rs, idex_rt;
  logic [15:0] EXMEM_ALUOUT, mem_addr, mem_wdata, WB_DATA, retire_count;
  logic        EXMEM_RegWriteEN, mem_rd_en, mem_wr_en, MEMWB_RegWriteEN, load_use_stall;
  logic [2:0]  EXMEM_DstRegNum, MEMWB_DstRegNum;
  int pass_cnt = 0, total_cnt = 0;
  logic [18:0] wb_q[$];
  logic [33:0] mem_q[$];
  logic [18:0] wb_e;
  logic [33:0] mem_e;
  logic [90:0] all_o;
  assign all_o = {EXMEM_ALUOUT, EXMEM_RegWriteEN, EXMEM_DstRegNum, mem_addr, mem_wdata, mem_rd_en, mem_wr_en,
                  WB_DATA, MEMWB_RegWriteEN, MEMWB_DstRegNum, load_use_stall, retire_count};
  exmem_memwb_fwd_source dut (
    .clk(clk), .rst(rst), .stall(stall), .ex_valid(ex_valid), .ex_flush(ex_flush),
    .ex_alu_out(ex_alu_out), .ex_store_data(ex_store_data), .ex_reg_write_en(ex_reg_write_en),
    .ex_dst_reg(ex_dst_reg), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .idex_rs(idex_rs), .idex_rt(idex_rt), .idex_rt_valid(idex_rt_valid), .mem_read_data(mem_read_data),
    .EXMEM_ALUOUT(EXMEM_ALUOUT), .EXMEM_RegWriteEN(EXMEM_RegWriteEN), .EXMEM_DstRegNum(EXMEM_DstRegNum),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en),
    .WB_DATA(WB_DATA), .MEMWB_RegWriteEN(MEMWB_RegWriteEN), .MEMWB_DstRegNum(MEMWB_DstRegNum),
    .load_use_stall(load_use_stall), .retire_count(retire_count)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drv(input logic v, input logic [15:0] alu, input logic [15:0] sd, input logic we,
                     input logic [2:0] dst, input logic rd, input logic wr);
    ex_valid = v; ex_alu_out = alu; ex_store_data = sd; ex_reg_write_en = we;
    ex_dst_reg = dst; ex_mem_read = rd; ex_mem_write = wr;
  endtask
  // a write-back or memory request is consumed only on a cycle the pipe is not frozen
  always @(negedge clk) begin
    if (!rst && !stall && MEMWB_RegWriteEN) begin
      if (wb_q.size() == 0) chk("wb_unexpected", {MEMWB_DstRegNum, WB_DATA}, 19'h0);
      else begin
        wb_e = wb_q.pop_front();
        chk("wb_write", {MEMWB_DstRegNum, WB_DATA}, wb_e);
      end
    end
    if (!rst && !stall && (mem_rd_en || mem_wr_en)) begin
      if (mem_q.size() == 0) chk("mem_unexpected", {mem_rd_en, mem_wr_en, mem_addr, mem_wdata}, 34'h0);
      else begin
        mem_e = mem_q.pop_front();
        chk("mem_req", {mem_rd_en, mem_wr_en, mem_addr, mem_wdata}, mem_e);
      end
    end
  end
  initial begin
    rst = 1'b1; stall = 1'b0; ex_flush = 1'b0; mem_read_data = 16'hBEEF;
    idex_rs = 3'd0; idex_rt = 3'd0; idex_rt_valid = 1'b0;
    drv(0, 0, 0, 0, 0, 0, 0);
    #1 chk("reset_outputs", all_o, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("post_release", all_o, 0);
    step();
    chk("first_cycle", all_o, 0);
    drv(1, 16'h1234, 0, 1, 3'd3, 0, 0);
    wb_q.push_back({3'd3, 16'h1234});
    step();
    chk("exmem_alu", EXMEM_ALUOUT, 16'h1234);
    chk("exmem_dst", EXMEM_DstRegNum, 3'd3);
    chk("exmem_we", EXMEM_RegWriteEN, 1'b1);
    drv(0, 0, 0, 0, 0, 0, 0);
    step();
    chk("wb_we", MEMWB_RegWriteEN, 1'b1);
    step();
    chk("retire_1", retire_count, 16'd1);
    drv(1, 16'h0040, 0, 1, 3'd2, 1, 0);
    mem_q.push_back({1'b1, 1'b0, 16'h0040, 16'h0000});
    wb_q.push_back({3'd2, 16'hBEEF});
    step();
    drv(1, 16'h0005, 0, 1, 3'd4, 0, 0);
    idex_rs = 3'd2;
    wb_q.push_back({3'd4, 16'h0005});
    #1 chk("lu_stall_rs", load_use_stall, 1'b1);
    chk("lu_rd_en", mem_rd_en, 1'b1);
    step();
    chk("lu_stall_clear", load_use_stall, 1'b0);
    chk("lu_bubble", {EXMEM_RegWriteEN, mem_rd_en, EXMEM_ALUOUT}, 0);
    chk("lu_wb_data", WB_DATA, 16'hBEEF);
    chk("lu_wb_dst", MEMWB_DstRegNum, 3'd2);
    step();
    drv(0, 0, 0, 0, 0, 0, 0);
    idex_rs = 3'd0;
    step();
    step();
    chk("retire_3", retire_count, 16'd3);
    drv(1, 16'h0042, 0, 1, 3'd2, 1, 0);
    mem_q.push_back({1'b1, 1'b0, 16'h0042, 16'h0000});
    wb_q.push_back({3'd2, 16'hBEEF});
    step();
    drv(1, 16'h0777, 0, 1, 3'd5, 0, 0);
    idex_rs = 3'd1; idex_rt = 3'd2; idex_rt_valid = 1'b0;
    wb_q.push_back({3'd5, 16'h0777});
    #1 chk("lu_rt_invalid", load_use_stall, 1'b0);
    idex_rt_valid = 1'b1;
    #1 chk("lu_rt_valid", load_use_stall, 1'b1);
    idex_rt_valid = 1'b0;
    #1;
    step();
    drv(0, 0, 0, 0, 0, 0, 0);
    idex_rs = 3'd0; idex_rt = 3'd0;
    step();
    step();
    chk("retire_5", retire_count, 16'd5);
    drv(1, 16'h0080, 16'hCAFE, 0, 3'd0, 0, 1);
    ex_flush = 1'b1;
    step();
    ex_flush = 1'b0;
    drv(0, 0, 0, 0, 0, 0, 0);
    chk("flush_bubble", {mem_wr_en, EXMEM_RegWriteEN, mem_addr, mem_wdata}, 0);
    step();
    step();
    chk("flush_retire", retire_count, 16'd5);
    drv(1, 16'h2222, 0, 1, 3'd6, 0, 0);
    wb_q.push_back({3'd6, 16'h2222});
    step();
    drv(1, 16'h0090, 16'h1111, 0, 3'd0, 0, 1);
    mem_q.push_back({1'b0, 1'b1, 16'h0090, 16'h1111});
    step();
    stall = 1'b1;
    drv(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      chk("stall_mem", {mem_wr_en, mem_addr, mem_wdata}, {1'b1, 16'h0090, 16'h1111});
      chk("stall_wb", {MEMWB_RegWriteEN, MEMWB_DstRegNum, WB_DATA, retire_count}, {1'b1, 3'd6, 16'h2222, 16'd5});
      step();
    end
    stall = 1'b0;
    step();
    chk("resume_adv", {mem_wr_en, retire_count}, {1'b0, 16'd6});
    step();
    chk("resume_store", {MEMWB_RegWriteEN, retire_count}, {1'b0, 16'd7});
    drv(1, 16'h0101, 0, 1, 3'd1, 0, 0);
    step();
    drv(1, 16'h0202, 0, 1, 3'd7, 0, 0);
    step();
    drv(0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    #1 chk("async_reset", all_o, 0);
    #2 rst = 1'b0;
    step();
    chk("after_reset", all_o, 0);
    drv(1, 0, 0, 0, 3'd0, 0, 0);
    repeat (65535) step();
    drv(0, 0, 0, 0, 0, 0, 0);
    step();
    step();
    chk("preload_ffff", retire_count, 16'hFFFF);
    drv(1, 16'h00AA, 0, 1, 3'd1, 0, 0);
    wb_q.push_back({3'd1, 16'h00AA});
    step();
    drv(0, 0, 0, 0, 0, 0, 0);
    step();
    step();
    chk("wrap_zero", retire_count, 16'd0);
    for (int i = 0; i < 20 && (wb_q.size() != 0 || mem_q.size() != 0); i++) step();
    chk("wb_drain", wb_q.size(), 0);
    chk("mem_drain", mem_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
